// File: rtl/read_scheduler.sv
// Drains four 6-entry packet buffers, one read per period: the eligible buffer with the highest
// occupancy wins, and ties go round-robin from the buffer after the last one read.
module read_scheduler #(
   parameter int unsigned READ_PERIOD = 150_000_000,
   parameter int unsigned CNT_W       = 28
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [17:0] buffer1_i,
   input  logic [17:0] buffer2_i,
   input  logic [17:0] buffer3_i,
   input  logic [17:0] buffer4_i,
   output logic [3:0]  pop,
   output logic        read_valid,
   output logic [3:0]  read_data,
   output logic [7:0]  read_count,
   output logic [1:0]  last_buf
);

   typedef enum logic [1:0] {StWait, StSelect, StPop, StHold} state_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(READ_PERIOD - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [3:0]       pop_q, pop_d;
   logic             rv_q, rv_d;
   logic [3:0]       data_q, data_d;
   logic [7:0]       count_q, count_d;
   logic [1:0]       last_q, last_d;

   logic [3:0][17:0] bufs;
   logic [2:0]       occ [4];
   logic             sel_found;
   logic [1:0]       sel_idx;
   logic [2:0]       sel_occ;
   logic [1:0]       rr_idx;
   logic [1:0]       sel_pay;

   assign bufs = {buffer4_i, buffer3_i, buffer2_i, buffer1_i};

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         occ[k] = '0;
         for (int i = 0; i < 6; i++) begin
            occ[k] = occ[k] + 3'(bufs[k][3*i]);
         end
      end
   end

   // Scan in round-robin order; strict '>' keeps the earliest buffer on an occupancy tie.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = last_q;
      sel_occ   = '0;
      rr_idx    = '0;
      for (int off = 1; off <= 4; off++) begin
         rr_idx = last_q + 2'(off);
         if (bufs[rr_idx][0] && (!sel_found || occ[rr_idx] > sel_occ)) begin
            sel_found = 1'b1;
            sel_idx   = rr_idx;
            sel_occ   = occ[rr_idx];
         end
      end
   end

   assign sel_pay = bufs[sel_idx][2:1];

   always_comb begin
      tick_d = enable && (cnt_q == CntMax);
      cnt_d  = cnt_q;
      if (enable) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pop_d   = '0;
      rv_d    = 1'b0;
      data_d  = data_q;
      count_d = count_q;
      last_d  = last_q;
      unique case (state_q)
         StWait: begin
            if (tick_q) state_d = StSelect;
         end
         StSelect: begin
            if (sel_found) begin
               state_d = StPop;
               pop_d   = 4'b0001 << sel_idx;
               rv_d    = 1'b1;
               data_d  = {sel_idx, sel_pay};
               count_d = count_q + 8'd1;
               last_d  = sel_idx;
            end else begin
               state_d = StWait;
            end
         end
         StPop:   state_d = StHold;
         StHold:  state_d = StWait;
         default: state_d = StWait;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StWait;
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         pop_q   <= '0;
         rv_q    <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         pop_q   <= pop_d;
         rv_q    <= rv_d;
         data_q  <= data_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign pop        = pop_q;
   assign read_valid = rv_q;
   assign read_data  = data_q;
   assign read_count = count_q;
   assign last_buf   = last_q;

endmodule

// File: tb/tb_read_scheduler.sv
// Bench for read_scheduler: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level reference model.
module tb_read_scheduler;

   localparam int P = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [17:0] b1 = '0, b2 = '0, b3 = '0, b4 = '0;
   logic [3:0]  pop;
   logic        read_valid;
   logic [3:0]  read_data;
   logic [7:0]  read_count;
   logic [1:0]  last_buf;

   read_scheduler #(.READ_PERIOD(P), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .buffer1_i (b1),
      .buffer2_i (b2),
      .buffer3_i (b3),
      .buffer4_i (b4),
      .pop       (pop),
      .read_valid(read_valid),
      .read_data (read_data),
      .read_count(read_count),
      .last_buf  (last_buf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: enabled-cycle count, tick seen, read phase (0 idle, 1 choosing, 2 popped, 3 settle)
   int         m_cnt, m_phase;
   bit         m_tick;
   logic [3:0] e_pop;
   logic       e_rv;
   logic [3:0] e_data;
   logic [7:0] e_count;
   logic [1:0] e_last;

   int         cyc, first_pop, rv_cycles;
   logic [3:0] pop_log[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int occupancy(input logic [17:0] b);
      int n = 0;
      for (int i = 0; i < 6; i++) n += int'(b[3*i]);
      return n;
   endfunction

   function automatic int pick(input int last);
      logic [17:0] bs[4];
      int best = -1;
      int bn = -1;
      bs[0] = b1; bs[1] = b2; bs[2] = b3; bs[3] = b4;
      for (int off = 1; off <= 4; off++) begin
         int k = (last + off) % 4;
         if (bs[k][0] && occupancy(bs[k]) > bn) begin
            best = k;
            bn = occupancy(bs[k]);
         end
      end
      return best;
   endfunction

   function automatic logic [1:0] head_payload(input int k);
      logic [17:0] bs[4];
      bs[0] = b1; bs[1] = b2; bs[2] = b3; bs[3] = b4;
      return bs[k][2:1];
   endfunction

   // Predict outputs after the coming edge from the inputs currently applied.
   task automatic model_edge();
      bit nt;
      int w;
      if (rst) begin
         m_cnt = 0; m_tick = 0; m_phase = 0;
         e_pop = '0; e_rv = 0; e_data = '0; e_count = '0; e_last = 2'd3;
         return;
      end
      nt = enable && (m_cnt == P - 1);
      if (enable) m_cnt = (m_cnt + 1) % P;
      e_pop = '0;
      e_rv  = 1'b0;
      case (m_phase)
         0: if (m_tick) m_phase = 1;
         1: begin
            w = pick(int'(e_last));
            if (w < 0) m_phase = 0;
            else begin
               m_phase = 2;
               e_pop   = 4'(1 << w);
               e_rv    = 1'b1;
               e_data  = {2'(w), head_payload(w)};
               e_count = e_count + 8'd1;
               e_last  = 2'(w);
            end
         end
         2: m_phase = 3;
         default: m_phase = 0;
      endcase
      m_tick = nt;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      check_val("outs", {13'b0, pop, read_valid, read_data, read_count, last_buf},
                {13'b0, e_pop, e_rv, e_data, e_count, e_last});
      if (pop != 4'b0) begin
         pop_log.push_back(pop);
         if (first_pop < 0) first_pop = cyc;
      end
      if (read_valid) rv_cycles++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
      first_pop = -1;
      rv_cycles = 0;
      pop_log.delete();
   endtask

   // Contiguous valid entries from the head, random payloads.
   function automatic logic [17:0] rand_buf(input int n);
      logic [17:0] b = '0;
      for (int i = 0; i < n; i++) begin
         b[3*i]       = 1'b1;
         b[3*i+1]     = 1'($urandom);
         b[3*i+2]     = 1'($urandom);
      end
      return b;
   endfunction

   initial begin
      logic [3:0] rr_exp [5];
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
      cyc = 0;
      first_pop = -1;
      rv_cycles = 0;

      // Empty buffers: nothing ever read.
      do_reset();
      steps(40);
      check_val("empty_pops", pop_log.size(), 0);
      check_val("empty_count", read_count, 0);
      check_val("empty_last", last_buf, 3);

      // Single entry in buffer 3.
      do_reset();
      b3 = 18'b000_101;
      steps(12);
      check_val("single_lat", first_pop, 10);
      check_val("single_pop", (pop_log.size() > 0) ? pop_log[0] : 4'hF, 4'b0100);
      check_val("single_rv_len", rv_cycles, 1);
      check_val("single_data", read_data, 4'b1010);
      check_val("single_count", read_count, 1);
      check_val("single_last", last_buf, 2);

      // Occupancy beats round-robin order.
      do_reset();
      b3 = '0;
      b1 = rand_buf(2);
      b4 = rand_buf(5);
      b4[2:0] = 3'b011;
      steps(12);
      check_val("prio_pop", (pop_log.size() > 0) ? pop_log[0] : 4'hF, 4'b1000);
      check_val("prio_data", read_data, 4'b1101);

      // Equal occupancy: pure round robin.
      do_reset();
      b1 = rand_buf(3); b2 = rand_buf(3); b3 = rand_buf(3); b4 = rand_buf(3);
      steps(44);
      check_val("rr_num", pop_log.size(), 5);
      for (int i = 0; i < 5 && i < pop_log.size(); i++) check_val("rr_pop", pop_log[i], rr_exp[i]);
      check_val("rr_count", read_count, 5);

      // Enable held low for 10 cycles delays the read by exactly 10.
      do_reset();
      b1 = '0; b3 = '0; b4 = '0;
      b2 = rand_buf(1);
      steps(2);
      enable = 1'b0;
      steps(10);
      enable = 1'b1;
      steps(12);
      check_val("gap_lat", first_pop, 20);

      // Reset while choosing: no read happens.
      do_reset();
      b2 = '0;
      b1 = rand_buf(2);
      steps(9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      steps(3);
      check_val("rst_sel_pops", pop_log.size(), 0);
      check_val("rst_sel_count", read_count, 0);

      // Occupied buffer with an empty head is never eligible.
      do_reset();
      b1 = '0;
      b2 = rand_buf(6);
      b2[0] = 1'b0;
      steps(30);
      check_val("nohead_pops", pop_log.size(), 0);

      // Read counter wraps after 256 reads.
      do_reset();
      b2 = '0;
      b1 = rand_buf(1);
      steps(256 * P + 2);
      check_val("wrap_reads", pop_log.size(), 256);
      check_val("wrap_count", read_count, 0);

      // Randomized traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         rst    = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) begin
            b1 = rand_buf($urandom_range(0, 6));
            b2 = rand_buf($urandom_range(0, 6));
            b3 = rand_buf($urandom_range(0, 6));
            b4 = ($urandom_range(0, 1) != 0) ? 18'($urandom) : rand_buf($urandom_range(0, 6));
         end
         step();
      end
      rst = 1'b0;
      enable = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
